// File: rtl/regfile_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_pkg
//
// Shared definitions for the debug register-dump unit:
//   - state_t     : dump FSM states (IDLE, HDR, READ, SEND, DONE)
//   - HEADER_BASE : upper pattern of the optional header word
//   - reg_idx_t   : 4-bit register index as used by the register file
//   - header_word : header word for a given dump range
// -----------------------------------------------------------------------------
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    READ = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] HEADER_BASE = 32'hA5A5_0000;

  typedef logic [3:0] reg_idx_t;

  // Header carries the number of register words that follow it.
  function automatic logic [31:0] header_word(input int unsigned first_reg,
                                              input int unsigned last_reg);
    return HEADER_BASE | 32'(last_reg - first_reg + 1);
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//
// Debug register-dump unit. A start pulse in IDLE walks register indices
// FIRST_REG..LAST_REG through a spare register-file read port, one index per
// word, captures each read value and presents the words in order on an
// output stream. The register file is only read, never written.
//
// Optional feature (compile-time macro REGFILE_DUMP_HEADER_EN):
//   when defined, one header word HEADER_BASE | (LAST_REG-FIRST_REG+1) is sent
//   before the first register word (out_last never set on it).
//
// Parameters:
//   FIRST_REG  first register index dumped (0..15)
//   LAST_REG   last register index dumped (FIRST_REG..15)
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   dump request, sampled only in IDLE
//   rf_addr    out  4   register-file read address
//   rf_data    in   32  combinational register-file read data for rf_addr
//   out_valid  out  1   out_data holds a valid word
//   out_ready  in   1   downstream accepts the word
//   out_data   out  32  dumped word
//   out_last   out  1   final word of the dump
//   busy       out  1   dump in progress
//   done       out  1   one-cycle pulse after the last word is accepted
//   dbg_state  out  3   current FSM state (state_t encoding)
//
// Stream handshake: a word transfers on a rising edge where
// out_valid && out_ready. Once out_valid is raised, out_valid, out_data and
// out_last hold unchanged until that transfer; out_valid never depends on
// out_ready.
// -----------------------------------------------------------------------------
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  localparam reg_idx_t FIRST_IDX = reg_idx_t'(FIRST_REG);
  localparam reg_idx_t LAST_IDX  = reg_idx_t'(LAST_REG);

`ifdef REGFILE_DUMP_HEADER_EN
  localparam logic [31:0] HEADER_WORD =
    header_word(int'(FIRST_REG), int'(LAST_REG));
`endif

  state_t      r_state;
  reg_idx_t    r_index;
  reg_idx_t    r_rf_addr;
  logic [31:0] r_out_data;   // doubles as the capture/holding register
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_busy;
  logic        r_done;

  logic        w_hs;
  logic        w_is_last;

  assign w_hs      = r_out_valid & out_ready;
  assign w_is_last = (r_index == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_index     <= '0;
      r_rf_addr   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_index   <= FIRST_IDX;
            // Address is set up here so the register file output is already
            // settled for the whole READ cycle.
            r_rf_addr <= FIRST_IDX;
            r_busy    <= 1'b1;
`ifdef REGFILE_DUMP_HEADER_EN
            r_out_valid <= 1'b1;
            r_out_data  <= HEADER_WORD;
            r_out_last  <= 1'b0;
            r_state     <= HDR;
`else
            r_state     <= READ;
`endif
          end
        end

        HDR: begin
`ifdef REGFILE_DUMP_HEADER_EN
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= READ;
          end
`else
          r_state <= IDLE;
`endif
        end

        READ: begin
          // Snapshot of the register; later writes are not reflected.
          r_out_data  <= rf_data;
          r_out_last  <= w_is_last;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end

        SEND: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (w_is_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              // Never wraps: the last index stops the walk at or below 15.
              r_index   <= r_index + 4'd1;
              r_rf_addr <= r_index + 4'd1;
              r_state   <= READ;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rf_addr   = r_rf_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_dump.sv
`timescale 1ns/1ps
module tb_regfile_dump;

  localparam int NCH = 3;
`ifdef REGFILE_DUMP_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT channels ----------------
  // ch0: regs 0..15, ch1: reg 15 only, ch2: regs 2..5
  logic        start_v[NCH];
  logic        ready_v[NCH];
  logic [3:0]  rf_addr_v[NCH];
  logic [31:0] rf_data_v[NCH];
  logic [31:0] out_data_v[NCH];
  logic        valid_v[NCH];
  logic        last_v[NCH];
  logic        busy_v[NCH];
  logic        done_v[NCH];
  logic [2:0]  dbg_v[NCH];

  logic [31:0] regs[16];   // register-file model; regs[15] plays PC+8

  assign rf_data_v[0] = regs[rf_addr_v[0]];
  assign rf_data_v[1] = regs[rf_addr_v[1]];
  assign rf_data_v[2] = regs[rf_addr_v[2]];

  regfile_dump #(.FIRST_REG(0), .LAST_REG(15)) u_full (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .rf_addr(rf_addr_v[0]),
    .rf_data(rf_data_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0]),
    .out_data(out_data_v[0]), .out_last(last_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .dbg_state(dbg_v[0]));

  regfile_dump #(.FIRST_REG(15), .LAST_REG(15)) u_pc (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .rf_addr(rf_addr_v[1]),
    .rf_data(rf_data_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1]),
    .out_data(out_data_v[1]), .out_last(last_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .dbg_state(dbg_v[1]));

  regfile_dump #(.FIRST_REG(2), .LAST_REG(5)) u_mid (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .rf_addr(rf_addr_v[2]),
    .rf_data(rf_data_v[2]), .out_valid(valid_v[2]), .out_ready(ready_v[2]),
    .out_data(out_data_v[2]), .out_last(last_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .dbg_state(dbg_v[2]));

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  int          sel = 0;
  int          nreg = 0;
  int          hs_cnt = 0;
  int          stalls = 0;
  int          done_cnt = 0;
  int          start_cyc = 0;
  bit          done_seen = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  // ready driver control
  int ready_mode = 0;   // 0: always ready, 1: random, 2: 5-cycle stall on word 3
  int stall_left = 0;
  bit stall_used = 0;
  int stall_at;
  initial stall_at = 2 + HDR_WORDS;

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < NCH; k++) if (k != sel) ready_v[k] = 1'b1;
    if (ready_mode == 2 && !stall_used && valid_v[sel] && hs_cnt == stall_at) begin
      stall_left = 5;
      stall_used = 1;
    end
    if (stall_left > 0) begin
      ready_v[sel] = 1'b0;
      stall_left--;
    end else if (ready_mode == 1) begin
      ready_v[sel] = ($urandom_range(0, 3) != 0);
    end else begin
      ready_v[sel] = 1'b1;
    end
  end

  // monitor: sampled mid-cycle
  always @(negedge clk) begin
    logic [31:0] e;
    logic        el;
    if (reset_n) begin
      if (prev_stall) begin
        check("hold_valid", valid_v[sel], 1);
        check("hold_data", out_data_v[sel], prev_data);
        check("hold_last", last_v[sel], prev_last);
      end
      prev_stall = valid_v[sel] && !ready_v[sel];
      prev_data  = out_data_v[sel];
      prev_last  = last_v[sel];
      if (valid_v[sel] && !ready_v[sel]) stalls++;
      if (valid_v[sel] && ready_v[sel]) begin
        hs_cnt++;
        check("busy_in_dump", busy_v[sel], 1);
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("word_data", out_data_v[sel], e);
          check("word_last", last_v[sel], el);
        end
      end
      if (done_v[sel]) begin
        done_cnt++;
        done_seen = 1;
        check("busy_at_done", busy_v[sel], 0);
        check("latency", cyc - start_cyc, 2 * nreg + 1 + HDR_WORDS + stalls);
        check("words_left", exp_q.size(), 0);
      end
    end else begin
      prev_stall = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_dump(input int ch, input int first, input int last, input int mode);
    exp_q.delete();
    exp_last_q.delete();
    if (HDR_WORDS != 0) begin
      exp_q.push_back(32'hA5A5_0000 + 32'(last - first + 1));
      exp_last_q.push_back(1'b0);
    end
    for (int i = first; i <= last; i++) begin
      exp_q.push_back(regs[i]);
      exp_last_q.push_back(i == last);
    end
    nreg       = last - first + 1;
    sel        = ch;
    hs_cnt     = 0;
    stalls     = 0;
    done_cnt   = 0;
    done_seen  = 0;
    prev_stall = 0;
    ready_mode = mode;
    stall_used = 0;
    stall_left = 0;
    @(posedge clk); #1;
    start_v[ch] = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1;
    start_v[ch] = 1'b0;
    check("busy_after_start", busy_v[ch], 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) @(posedge clk);
    check("done_seen", done_seen, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("done_low", done_v[sel], 0);
    check("idle_busy", busy_v[sel], 0);
    check("idle_valid", valid_v[sel], 0);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_valid"}, valid_v[0], 0);
    check({pfx, "_data"}, out_data_v[0], 0);
    check({pfx, "_last"}, last_v[0], 0);
    check({pfx, "_busy"}, busy_v[0], 0);
    check({pfx, "_done"}, done_v[0], 0);
    check({pfx, "_addr"}, rf_addr_v[0], 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < NCH; k++) begin
      start_v[k] = 1'b0;
      ready_v[k] = 1'b1;
    end
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #2;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // full dump, always ready
    start_dump(0, 0, 15, 0);
    wait_done(200);

    // 5-cycle stall on word 3
    start_dump(0, 0, 15, 2);
    wait_done(200);
    check("stall_cycles", stalls, 5);

    // start pulsed again while busy is ignored
    start_dump(0, 0, 15, 0);
    repeat (4) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(200);
    repeat (4) @(posedge clk);
    #1;
    check("no_second_dump", valid_v[0], 0);
    check("single_done", done_cnt, 1);

    // asynchronous reset during word 7, then restart from the first register
    start_dump(0, 0, 15, 0);
    for (int i = 0; i < 200 && hs_cnt < 6 + HDR_WORDS; i++) @(posedge clk);
    check("reach_word7", hs_cnt >= 6 + HDR_WORDS, 1);
    #3 reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    repeat (3) @(posedge clk);
    check("no_done_in_reset", done_cnt, 0);
    #1 reset_n = 1'b1;
    start_dump(0, 0, 15, 0);
    wait_done(200);

    // single-word dump of r15 (PC+8)
    regs[15] = 32'h0000_0048;
    start_dump(1, 15, 15, 0);
    wait_done(50);

    // randomized contents and backpressure
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      start_dump(2, 2, 5, 1);
      wait_done(200);
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      start_dump(0, 0, 15, 1);
      wait_done(400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
